// File: rtl/peri_fabric_pkg.sv
// Shared types and constants for the peripheral register fabric.
// The optional timeout is enabled by defining PERI_FABRIC_TIMEOUT_EN.
package peri_fabric_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } fab_state_e;

  // Returned on a slave timeout so software can spot a dead slave.
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam int ERR_DEC_BIT = 0;
  localparam int ERR_TO_BIT  = 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } reg_req_t;

endpackage

// File: rtl/peri_reg_fabric_if.sv
// Upstream register-bus interface: the master issues requests, the fabric
// (slave side) answers with a single-cycle ack.
interface peri_reg_fabric_if;
  import peri_fabric_pkg::*;

  logic              reg_cs;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [BE_W-1:0]   reg_be;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  modport master (output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                  input  reg_rdata, reg_ack);
  modport slave  (input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
                  output reg_rdata, reg_ack);
endinterface

// File: rtl/peri_fabric_to_cnt.sv
// Slave-ack timeout counter; only instantiated when PERI_FABRIC_TIMEOUT_EN
// is defined. expire fires in the TO_CYC-th consecutive inc cycle.
module peri_fabric_to_cnt #(
  parameter int TO_CYC = 255,
  parameter int CNT_W  = 10
) (
  input  logic mclk,
  input  logic s_reset_n,
  input  logic load,
  input  logic inc,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge mclk) begin
    if (!s_reset_n)  cnt_q <= '0;
    else if (load)   cnt_q <= '0;
    else if (inc)    cnt_q <= cnt_q + 1'b1;
  end

  assign expire = inc && (cnt_q == CNT_W'(TO_CYC - 1));

endmodule

// File: rtl/peri_reg_fabric.sv
// Register-bus fabric: decodes one upstream access to one of NUM_SLV slaves.
// Define PERI_FABRIC_TIMEOUT_EN to abort accesses a slave never acks.
module peri_reg_fabric
  import peri_fabric_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 7,
  parameter int SEL_W   = 4,
  parameter int TO_CYC  = 255
) (
  input  logic                      mclk,
  input  logic                      s_reset_n,
  peri_reg_fabric_if.slave          rbus,
  output logic [NUM_SLV-1:0]        slv_cs,
  output logic                      slv_wr,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  output logic [BE_W-1:0]           slv_be,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  input  logic                      err_clr,
  output logic [1:0]                err_status,
  output logic                      err_intr
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || TO_CYC < 1 || TO_CYC > 1023) begin : g_param_chk
    $error("peri_reg_fabric: NUM_SLV or TO_CYC out of range");
  end

  fab_state_e        state_q, state_d;
  reg_req_t          hold_q;
  logic [SEL_W-1:0]  idx_in, idx_q;
  logic              in_range, ack_hit, to_expire;
  logic [DATA_W-1:0] sel_rdata, rdata_q;
  logic [1:0]        err_q, err_set;

  assign idx_in   = rbus.reg_addr[SEL_LSB+SEL_W-1:SEL_LSB];
  assign idx_q    = hold_q.addr[SEL_LSB+SEL_W-1:SEL_LSB];
  assign in_range = (int'(idx_in) < NUM_SLV);

  always_comb begin
    slv_cs    = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_cs[i] = (state_q == ST_ACCESS) && (idx_q == SEL_W'(i));
      if (idx_q == SEL_W'(i)) sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  // slv_cs is one-hot on idx, so masking the ack with it drops foreign acks.
  assign ack_hit = |(slv_ack & slv_cs);

`ifdef PERI_FABRIC_TIMEOUT_EN
  localparam logic [1:0] ERR_MASK = 2'b11;

  peri_fabric_to_cnt #(.TO_CYC(TO_CYC), .CNT_W(10)) u_to_cnt (
    .mclk      (mclk),
    .s_reset_n (s_reset_n),
    .load      ((state_q == ST_IDLE) && rbus.reg_cs && in_range),
    .inc       (state_q == ST_ACCESS),
    .expire    (to_expire)
  );
`else
  localparam logic [1:0] ERR_MASK = 2'b01;

  assign to_expire = 1'b0;
`endif

  always_comb begin
    err_set              = '0;
    err_set[ERR_DEC_BIT] = (state_q == ST_IDLE) && rbus.reg_cs && !in_range;
    err_set[ERR_TO_BIT]  = (state_q == ST_ACCESS) && !ack_hit && to_expire;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rbus.reg_cs) state_d = in_range ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (ack_hit || to_expire) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!s_reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && rbus.reg_cs)
        hold_q <= '{wr: rbus.reg_wr, addr: rbus.reg_addr,
                    wdata: rbus.reg_wdata, be: rbus.reg_be};
      // Ack takes priority over a timeout expiring in the same cycle.
      if (state_q == ST_IDLE && rbus.reg_cs && !in_range) rdata_q <= '0;
      else if (state_q == ST_ACCESS && ack_hit)           rdata_q <= sel_rdata;
      else if (state_q == ST_ACCESS && to_expire)         rdata_q <= ERR_RDATA;
      err_q <= (err_clr ? 2'b00 : err_q) | err_set;
    end
  end

  assign slv_wr         = hold_q.wr;
  assign slv_addr       = hold_q.addr;
  assign slv_wdata      = hold_q.wdata;
  assign slv_be         = hold_q.be;
  assign rbus.reg_ack   = (state_q == ST_RESP);
  assign rbus.reg_rdata = rbus.reg_ack ? rdata_q : '0;
  assign err_status     = err_q & ERR_MASK;
  assign err_intr       = |err_status;

endmodule

// File: tb/tb_peri_reg_fabric.sv
// Directed bench for peri_reg_fabric: vector table plus corner-case sequences.
module tb_peri_reg_fabric;
  import peri_fabric_pkg::*;

  localparam int NUM_SLV = 4;
  localparam int TO      = 8;

  logic                      mclk = 1'b0;
  logic                      s_reset_n = 1'b0;
  logic [NUM_SLV-1:0]        slv_cs, slv_ack;
  logic                      slv_wr;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [BE_W-1:0]           slv_be;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic                      err_clr;
  logic [1:0]                err_status;
  logic                      err_intr;

  always #5 mclk = ~mclk;

  peri_reg_fabric_if bus ();

  peri_reg_fabric #(.NUM_SLV(NUM_SLV), .SEL_LSB(7), .SEL_W(4), .TO_CYC(TO)) u_dut (
    .mclk       (mclk),
    .s_reset_n  (s_reset_n),
    .rbus       (bus),
    .slv_cs     (slv_cs),
    .slv_wr     (slv_wr),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_be     (slv_be),
    .slv_rdata  (slv_rdata),
    .slv_ack    (slv_ack),
    .err_clr    (err_clr),
    .err_status (err_status),
    .err_intr   (err_intr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Issues one access and plays a slave that acks in its ack_dly-th cs cycle
  // (0 = never). Upstream fields are scrambled after the request edge.
  task automatic run_txn(input logic wr, input logic [10:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int ack_dly, input logic [31:0] srdata,
                         output int cs_cyc, output int ack_cyc, output int ack_pulses,
                         output logic [31:0] rdata, output bit fld_ok, output bit rd0_ok);
    int idx;
    logic [NUM_SLV-1:0] exp_cs;
    idx = int'(addr[10:7]);
    exp_cs = (idx < NUM_SLV) ? (NUM_SLV'(1) << idx) : '0;
    cs_cyc = 0; ack_cyc = 0; ack_pulses = 0; rdata = '0; fld_ok = 1'b1; rd0_ok = 1'b1;
    bus.reg_cs = 1'b1; bus.reg_wr = wr; bus.reg_addr = addr; bus.reg_wdata = wdata; bus.reg_be = be;
    tick();
    bus.reg_cs = 1'b0; bus.reg_wr = ~wr; bus.reg_addr = ~addr; bus.reg_wdata = ~wdata; bus.reg_be = ~be;
    for (int c = 1; c <= 40; c++) begin
      slv_ack = '0;
      if (slv_cs != '0) begin
        cs_cyc++;
        if (slv_cs !== exp_cs || slv_wr !== wr || slv_addr !== addr ||
            slv_wdata !== wdata || slv_be !== be) fld_ok = 1'b0;
        if (ack_dly != 0 && cs_cyc == ack_dly) begin
          slv_ack[idx] = 1'b1;
          slv_rdata[idx*32 +: 32] = srdata;
        end
      end
      if (bus.reg_ack) begin
        ack_pulses++;
        if (ack_cyc == 0) begin ack_cyc = c; rdata = bus.reg_rdata; end
      end else if (bus.reg_rdata !== '0) rd0_ok = 1'b0;
      if (ack_cyc != 0 && c > ack_cyc) break;
      tick();
    end
    slv_ack = '0;
  endtask

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_dly;
    logic [31:0] srdata;
    int          exp_cs;
    int          exp_ack;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cyc, ack_cyc, pulses;
    logic [31:0] rdata;
    bit fld_ok, rd0_ok, ok;
    logic [2:0] ack_pat;

    vt[0] = '{1'b1, 11'h100, 32'h1234_5678, 4'hF, 3, 32'h0000_0000, 3, 4, 32'h0000_0000, 2'b00};
    vt[1] = '{1'b0, 11'h004, 32'h0000_0000, 4'hF, 1, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 2'b00};
    vt[2] = '{1'b0, 11'h380, 32'h0000_0000, 4'hF, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 2'b01};
    vt[3] = '{1'b0, 11'h190, 32'h0000_0000, 4'hF, 5, 32'hA5A5_0003, 5, 6, 32'hA5A5_0003, 2'b00};
    vt[4] = '{1'b1, 11'h08C, 32'h0BAD_F00D, 4'h3, 2, 32'h1111_2222, 2, 3, 32'h1111_2222, 2'b00};

    bus.reg_cs = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_be = '0;
    slv_ack = '0; err_clr = 1'b0;
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    s_reset_n = 1'b0;
    repeat (3) tick();
    check("reset slv_cs", 64'(slv_cs), 64'h0);
    check("reset reg_ack", 64'(bus.reg_ack), 64'h0);
    check("reset reg_rdata", 64'(bus.reg_rdata), 64'h0);
    check("reset err_status", 64'(err_status), 64'h0);
    check("reset err_intr", 64'(err_intr), 64'h0);
    s_reset_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      run_txn(vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].be, vt[v].ack_dly, vt[v].srdata,
              cs_cyc, ack_cyc, pulses, rdata, fld_ok, rd0_ok);
      check($sformatf("v%0d cs cycles", v), 64'(cs_cyc), 64'(vt[v].exp_cs));
      check($sformatf("v%0d ack cycle", v), 64'(ack_cyc), 64'(vt[v].exp_ack));
      check($sformatf("v%0d ack pulses", v), 64'(pulses), 64'd1);
      check($sformatf("v%0d reg_rdata", v), 64'(rdata), 64'(vt[v].exp_rdata));
      check($sformatf("v%0d slave fields", v), 64'(fld_ok), 64'd1);
      check($sformatf("v%0d rdata zero idle", v), 64'(rd0_ok), 64'd1);
      check($sformatf("v%0d err_status", v), 64'(err_status), 64'(vt[v].exp_err));
      check($sformatf("v%0d err_intr", v), 64'(err_intr), 64'(|vt[v].exp_err));
    end

    // Decode error while err_clr is held: set wins, then clear takes effect.
    err_clr = 1'b1; bus.reg_cs = 1'b1; bus.reg_addr = 11'h380;
    tick();
    bus.reg_cs = 1'b0;
    check("set over clear err_status", 64'(err_status), 64'h1);
    check("set over clear err_intr", 64'(err_intr), 64'h1);
    tick();
    check("err_clr err_status", 64'(err_status), 64'h0);
    check("err_clr err_intr", 64'(err_intr), 64'h0);
    err_clr = 1'b0;

    // reg_cs held high: a new decode-error transaction starts right after RESP.
    bus.reg_cs = 1'b1; bus.reg_addr = 11'h380; ack_pat = '0;
    for (int c = 0; c < 3; c++) begin tick(); ack_pat[c] = bus.reg_ack; end
    bus.reg_cs = 1'b0;
    check("back-to-back ack pattern", 64'(ack_pat), 64'h5);
    tick(); tick();

    // Acks from slave 1 must not finish an access to slave 3.
    bus.reg_cs = 1'b1; bus.reg_addr = 11'h180;
    tick();
    bus.reg_cs = 1'b0; ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      slv_ack = 4'b0010;
      tick();
      if (slv_cs !== 4'b1000 || bus.reg_ack !== 1'b0) ok = 1'b0;
    end
    check("foreign ack ignored", 64'(ok), 64'd1);
    slv_ack = 4'b1000; slv_rdata[96 +: 32] = 32'h3333_AAAA;
    tick();
    slv_ack = '0;
    check("own ack reg_ack", 64'(bus.reg_ack), 64'h1);
    check("own ack reg_rdata", 64'(bus.reg_rdata), 64'h3333_AAAA);
    tick();

    // Reset during ACCESS (sticky error pending from earlier decode error).
    bus.reg_cs = 1'b1; bus.reg_addr = 11'h380; tick(); bus.reg_cs = 1'b0; tick();
    bus.reg_cs = 1'b1; bus.reg_addr = 11'h100; tick();
    bus.reg_cs = 1'b0;
    check("pre-reset slv_cs", 64'(slv_cs), 64'h4);
    tick();
    s_reset_n = 1'b0;
    tick();
    check("mid reset slv_cs", 64'(slv_cs), 64'h0);
    check("mid reset reg_ack", 64'(bus.reg_ack), 64'h0);
    check("mid reset reg_rdata", 64'(bus.reg_rdata), 64'h0);
    check("mid reset err_status", 64'(err_status), 64'h0);
    check("mid reset err_intr", 64'(err_intr), 64'h0);
    check("mid reset slv_addr", 64'(slv_addr), 64'h0);
    s_reset_n = 1'b1; ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.reg_ack !== 1'b0 || slv_cs !== '0) ok = 1'b0;
    end
    check("no ack after reset", 64'(ok), 64'd1);

`ifdef PERI_FABRIC_TIMEOUT_EN
    run_txn(1'b0, 11'h080, 32'h0, 4'hF, 0, 32'h0, cs_cyc, ack_cyc, pulses, rdata, fld_ok, rd0_ok);
    check("timeout cs cycles", 64'(cs_cyc), 64'(TO));
    check("timeout ack cycle", 64'(ack_cyc), 64'(TO + 1));
    check("timeout reg_rdata", 64'(rdata), 64'hDEAD_BEEF);
    check("timeout err_status", 64'(err_status), 64'h2);
    check("timeout err_intr", 64'(err_intr), 64'h1);
`else
    bus.reg_cs = 1'b1; bus.reg_addr = 11'h080; tick();
    bus.reg_cs = 1'b0; ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (slv_cs !== 4'b0010 || bus.reg_ack !== 1'b0) ok = 1'b0;
      tick();
    end
    check("no-timeout wait holds", 64'(ok), 64'd1);
    check("no-timeout err_status", 64'(err_status), 64'h0);
    slv_ack = 4'b0010; slv_rdata[32 +: 32] = 32'h5A5A_1111;
    tick();
    slv_ack = '0;
    check("late ack reg_ack", 64'(bus.reg_ack), 64'h1);
    check("late ack reg_rdata", 64'(bus.reg_rdata), 64'h5A5A_1111);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peri_reg_fabric.md
PERI_REG_FABRIC -- requirements
Module: peri_reg_fabric

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, meaning number of register-bus slaves (1..16).
REQ-002 SHALL have parameter SEL_LSB, default 7, meaning LSB of the slave-select field in reg_addr.
REQ-003 SHALL have parameter SEL_W, default 4, meaning width of the slave-select field.
REQ-004 SHALL have parameter TO_CYC, default 255, meaning slave-ack timeout in mclk cycles (1..1023).
REQ-005 SHALL use one clock and a synchronous active-low reset; ports: mclk input 1, the clock; s_reset_n input 1, synchronous active-low reset.
REQ-006 SHALL have upstream ports: reg_cs in 1; reg_wr in 1; reg_addr in 11; reg_wdata in 32; reg_be in 4; reg_rdata out 32; reg_ack out 1.
REQ-007 SHALL have downstream ports: slv_cs out NUM_SLV; slv_wr out 1; slv_addr out 11; slv_wdata out 32; slv_be out 4; slv_rdata in NUM_SLV*32 (slave i at bits 32i+31:32i); slv_ack in NUM_SLV.
REQ-008 SHALL have error ports: err_clr in 1, clears sticky status; err_status out 2 ({timeout, decode_err}, sticky); err_intr out 1, OR of err_status.

Function
REQ-009 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-010 IDLE: on reg_cs=1, latch reg_wr/addr/wdata/be into holding registers; idx = reg_addr[SEL_LSB+SEL_W-1:SEL_LSB].
REQ-011 IDLE, idx<NUM_SLV: next state ACCESS; slv_cs[idx]=1 from next cycle, all other slv_cs bits 0.
REQ-012 IDLE, idx>=NUM_SLV: next state RESP with response data 0; set err_status[0]; no slv_cs asserted.
REQ-013 ACCESS: hold slv_cs[idx] and slv_* from holding registers; on slv_ack[idx]=1 capture slave idx rdata, drop slv_cs next cycle, go RESP.
REQ-014 ACCESS: ignore slv_ack bits other than idx.
REQ-015 RESP: reg_ack=1 for exactly one cycle with captured reg_rdata; next state IDLE; reg_rdata=0 whenever reg_ack=0.
REQ-016 Latency: reg_cs sampled at cycle 0; slv_cs high at cycle 1; slave ack at cycle k>=1; reg_ack at cycle k+1. Decode error: reg_ack at cycle 1.
REQ-017 Upstream changes on reg_* during ACCESS/RESP SHALL be ignored; reg_cs still high in IDLE after RESP starts a new transaction.
REQ-018 err_clr=1 SHALL clear err_status on the next edge; a simultaneous set SHALL win over clear.
REQ-019 slv_ack arriving in the same cycle the timeout fires SHALL be treated as a normal ack (ack wins).

Reset
REQ-020 s_reset_n=0 at an edge SHALL force IDLE; slv_cs=0, reg_ack=0, reg_rdata=0, err_status=0, err_intr=0, timeout counter=0, holding registers=0.
REQ-021 Reset mid-ACCESS SHALL drop slv_cs the following cycle with no reg_ack issued.

Configuration
REQ-022 Macro PERI_FABRIC_TIMEOUT_EN SHALL gate the timeout.
REQ-023 With PERI_FABRIC_TIMEOUT_EN defined: counter clears on ACCESS entry, increments each ACCESS cycle; when it reaches TO_CYC without ack, drop slv_cs, response data = ERR_RDATA, set err_status[1], go RESP.
REQ-024 Without it: no counter logic; ACCESS waits indefinitely; err_status[1] tied 0.

Structure
REQ-025 Package peri_fabric_pkg SHALL hold the FSM state enum, ERR_RDATA (32'hDEAD_BEEF) and err_status bit-position constants.
REQ-026 Sub-module peri_fabric_to_cnt (timeout counter, load/inc/expire) SHALL be instantiated only under PERI_FABRIC_TIMEOUT_EN.

Verification
REQ-027 Write slave 2 (reg_addr=11'h100, wdata=32'h1234_5678, be=4'hF), ack in 3 cycles -> slv_cs=4'b0100 for 3 cycles, fields match, reg_ack one cycle after slv_ack.
REQ-028 Read slave 0, rdata=32'hCAFE_F00D, immediate ack -> reg_rdata=32'hCAFE_F00D with reg_ack at cycle 2.
REQ-029 Access idx=7 with NUM_SLV=4 -> no slv_cs, reg_ack at cycle 1, reg_rdata=0, err_status=2'b01, err_intr=1; err_clr -> 0.
REQ-030 Macro on, TO_CYC=8, slave never acks -> slv_cs high 8 cycles, reg_ack with 32'hDEAD_BEEF, err_status=2'b10.
REQ-031 Reset asserted cycle 2 of ACCESS -> slv_cs=0 next cycle, no reg_ack, all outputs at reset values.
REQ-032 slv_ack[1] asserted while accessing slave 3 -> ignored; transaction completes only on slv_ack[3].
